regfile_wb_arbiter: RTL and testbench

Shares the single register-file write port between two writeback sources. Source A is the single-cycle ALU writeback; source B is the long-latency load/mul-div writeback. Round-robin arbitration feeds a registered write stage that drives regwrite/rd/rd_data into the register file. A pending-write scoreboard, set at long-latency issue and cleared at B writeback, produces a RAW stall for the decode stage.

---
 rtl/regfile_wb_arbiter_if.sv | 28 ++
 rtl/regfile_wb_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result sources and the register-file write stage.
// Requester (master) drives valid/rd/data and sees ready plus the registered write port.
interface regfile_wb_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              a_valid;
  logic [REG_AW-1:0] a_rd;
  logic [XLEN-1:0]   a_data;
  logic              a_ready;
  logic              b_valid;
  logic [REG_AW-1:0] b_rd;
  logic [XLEN-1:0]   b_data;
  logic              b_ready;
  logic              regwrite;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   rd_data;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, regwrite, rd, rd_data
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, regwrite, rd, rd_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register-file write port (ALU vs long-latency) plus RAW scoreboard.
// Latency: accepted request -> regwrite one cycle later. Backpressure: only the conflict loser waits.
// Optional RFARB_PERF_EN adds saturating conflict_cnt / stall_cnt counters.
module regfile_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_wb_arbiter_if.slave wb,
  input  logic              sb_set_valid,
  input  logic [REG_AW-1:0] sb_set_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  output logic              stall,
  output logic              sb_err
`ifdef RFARB_PERF_EN
  ,
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_ent_t;

  logic                last_grant_b;
  logic                conflict;
  logic                a_fire;
  logic                b_fire;
  logic                wr_vld;
  wb_ent_t             sel;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic                double_set;

  // On a conflict the source that did not win last time gets the port.
  assign conflict   = wb.a_valid && wb.b_valid;
  assign wb.a_ready = wb.a_valid && (!wb.b_valid || last_grant_b);
  assign wb.b_ready = wb.b_valid && (!wb.a_valid || !last_grant_b);
  assign a_fire     = wb.a_valid && wb.a_ready;
  assign b_fire     = wb.b_valid && wb.b_ready;

  always_comb begin
    sel    = '{rd: wb.a_rd, data: wb.a_data};
    wr_vld = a_fire && (wb.a_rd != '0);
    if (b_fire) begin
      sel    = '{rd: wb.b_rd, data: wb.b_data};
      wr_vld = wb.b_rd != '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_b <= 1'b1;
      wb.regwrite  <= 1'b0;
      wb.rd        <= '0;
      wb.rd_data   <= '0;
    end else begin
      if (conflict) last_grant_b <= b_fire;
      wb.regwrite <= wr_vld;
      if (wr_vld) begin
        wb.rd      <= sel.rd;
        wb.rd_data <= sel.data;
      end
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (sb_set_valid && (sb_set_rd != '0)) set_mask[sb_set_rd] = 1'b1;
    if (b_fire && (wb.b_rd != '0))          clr_mask[wb.b_rd]   = 1'b1;
  end

  // A register cleared in the same cycle is free again, so re-setting it is legal.
  assign double_set = |(set_mask & pending & ~clr_mask);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
      sb_err  <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      sb_err  <= sb_err | double_set;
    end
  end

  assign stall = (rs1_used && (rs1 != '0) && pending[rs1]) ||
                 (rs2_used && (rs2 != '0) && pending[rs2]);

`ifdef RFARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (conflict && (conflict_cnt != 16'hFFFF)) conflict_cnt <= conflict_cnt + 16'd1;
      if (stall && (stall_cnt != 16'hFFFF))       stall_cnt    <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed checks of regfile_wb_arbiter against a behavioural reference model.
module tb_regfile_wb_arbiter;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  logic              clk;
  logic              rst_n;
  logic              sb_set_valid;
  logic [REG_AW-1:0] sb_set_rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              rs1_used;
  logic              rs2_used;
  logic              stall;
  logic              sb_err;
`ifdef RFARB_PERF_EN
  logic [15:0]       conflict_cnt;
  logic [15:0]       stall_cnt;
`endif

  regfile_wb_arbiter_if #(.XLEN(XLEN), .REG_AW(REG_AW)) wb ();

  regfile_wb_arbiter #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_REGS(NREG)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb           (wb.slave),
    .sb_set_valid (sb_set_valid),
    .sb_set_rd    (sb_set_rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .rs1_used     (rs1_used),
    .rs2_used     (rs2_used),
    .stall        (stall),
    .sb_err       (sb_err)
`ifdef RFARB_PERF_EN
    ,
    .conflict_cnt (conflict_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural view of write port, pending set and grant history.
  bit                m_regwrite;
  bit [REG_AW-1:0]   m_rd;
  bit [XLEN-1:0]     m_data;
  bit                m_known;
  bit                m_pend[NREG];
  bit                m_err;
  bit                m_b_won_last;
  int                m_ccnt;
  int                m_scnt;
  bit                e_ar;
  bit                e_br;

  // One clock cycle: inputs were set by the caller just after the previous edge.
  task automatic cycle();
    bit av, bv, e_st, clr, set;
    #3;
    av   = wb.a_valid;
    bv   = wb.b_valid;
    e_ar = av && (!bv || m_b_won_last);
    e_br = bv && (!av || !m_b_won_last);
    e_st = (rs1_used && rs1 != 0 && m_pend[rs1]) || (rs2_used && rs2 != 0 && m_pend[rs2]);
    if (rst_n) begin
      check_val("a_ready", 32'(wb.a_ready), 32'(e_ar));
      check_val("b_ready", 32'(wb.b_ready), 32'(e_br));
      check_val("stall",   32'(stall),      32'(e_st));
    end
    if (!rst_n) begin
      e_ar = 0; e_br = 0;
      m_regwrite = 0; m_rd = 0; m_data = 0; m_known = 1; m_err = 0;
      m_b_won_last = 1; m_ccnt = 0; m_scnt = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
    end else begin
      if (av && bv) m_b_won_last = e_br;
      m_regwrite = 0;
      if (e_ar) begin
        if (wb.a_rd != 0) begin m_regwrite = 1; m_rd = wb.a_rd; m_data = wb.a_data; m_known = 1; end
        else m_known = 0;
      end
      if (e_br) begin
        if (wb.b_rd != 0) begin m_regwrite = 1; m_rd = wb.b_rd; m_data = wb.b_data; m_known = 1; end
        else m_known = 0;
      end
      clr = e_br && wb.b_rd != 0;
      set = sb_set_valid && sb_set_rd != 0;
      if (set && m_pend[sb_set_rd] && !(clr && wb.b_rd == sb_set_rd)) m_err = 1;
      if (clr) m_pend[wb.b_rd] = 0;
      if (set) m_pend[sb_set_rd] = 1;
      if (av && bv && m_ccnt < 65535) m_ccnt++;
      if (e_st && m_scnt < 65535) m_scnt++;
    end
    @(posedge clk);
    #1;
    check_val("regwrite", 32'(wb.regwrite), 32'(m_regwrite));
    if (m_known) begin
      check_val("rd",      32'(wb.rd), 32'(m_rd));
      check_val("rd_data", wb.rd_data, m_data);
    end
    check_val("sb_err", 32'(sb_err), 32'(m_err));
`ifdef RFARB_PERF_EN
    check_val("conflict_cnt", 32'(conflict_cnt), m_ccnt[31:0]);
    check_val("stall_cnt",    32'(stall_cnt),    m_scnt[31:0]);
`endif
  endtask

  task automatic idle_inputs();
    wb.a_valid = 0; wb.a_rd = 0; wb.a_data = 0;
    wb.b_valid = 0; wb.b_rd = 0; wb.b_data = 0;
    sb_set_valid = 0; sb_set_rd = 0;
    rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    cycle();
    cycle();
    rst_n = 1;
  endtask

  initial begin
    bit a_hold, b_hold;
    int q[$];
    rst_n = 0;
    idle_inputs();

    // Reset with A requesting, then release: A accepted and written next cycle.
    wb.a_valid = 1; wb.a_rd = 9; wb.a_data = 32'h1234_5678;
    cycle();
    cycle();
    check_val("rst_rd",      32'(wb.rd), 32'd0);
    check_val("rst_rd_data", wb.rd_data, 32'd0);
    check_val("rst_stall",   32'(stall), 32'd0);
    rst_n = 1;
    cycle();
    idle_inputs();
    cycle();

    // Single A write, then idle.
    wb.a_valid = 1; wb.a_rd = 5; wb.a_data = 32'hDEADBEEF;
    cycle();
    idle_inputs();
    cycle();

    // Continuous conflict from reset: A,B,A,B...
    idle_inputs();
    do_reset();
    wb.a_valid = 1; wb.a_rd = 3; wb.a_data = 1;
    wb.b_valid = 1; wb.b_rd = 4; wb.b_data = 2;
    for (int i = 0; i < 8; i++) cycle();
    idle_inputs();
    cycle();

    // Scoreboard stall window around a B writeback of rd=7.
    do_reset();
    sb_set_valid = 1; sb_set_rd = 7;
    cycle();
    sb_set_valid = 0; rs1 = 7; rs1_used = 1;
    for (int i = 1; i < 10; i++) cycle();
    wb.b_valid = 1; wb.b_rd = 7; wb.b_data = 32'hCAFE_0007;
    cycle();
    wb.b_valid = 0;
    cycle();

    // Same-cycle set and clear keeps the bit; a later second set is an error.
    sb_set_valid = 1; sb_set_rd = 7;
    cycle();
    wb.b_valid = 1; wb.b_rd = 7; wb.b_data = 32'h77;
    cycle();
    wb.b_valid = 0; sb_set_valid = 0;
    cycle();
    sb_set_valid = 1;
    cycle();
    sb_set_valid = 0;
    for (int i = 0; i < 3; i++) cycle();

    // rd=0 is ignored by the scoreboard and never written.
    do_reset();
    sb_set_valid = 1; sb_set_rd = 0; rs1 = 0; rs1_used = 1;
    cycle();
    sb_set_valid = 0;
    cycle();
    wb.b_valid = 1; wb.b_rd = 0; wb.b_data = 32'hFFFF_FFFF;
    cycle();
    idle_inputs();
    cycle();

    // Randomized traffic; losers hold their request until accepted.
    do_reset();
    a_hold = 0; b_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!a_hold) begin
        wb.a_valid = $urandom_range(0, 1);
        wb.a_rd    = REG_AW'($urandom_range(0, NREG - 1));
        wb.a_data  = $urandom;
      end
      if (!b_hold) begin
        q.delete();
        foreach (m_pend[i]) if (m_pend[i]) q.push_back(i);
        wb.b_valid = ($urandom_range(0, 2) == 0);
        wb.b_rd    = (q.size() > 0 && $urandom_range(0, 3) != 0)
                     ? REG_AW'(q[$urandom_range(0, q.size() - 1)])
                     : REG_AW'($urandom_range(0, NREG - 1));
        wb.b_data  = $urandom;
      end
      sb_set_rd    = REG_AW'($urandom_range(0, NREG - 1));
      sb_set_valid = ($urandom_range(0, 3) == 0) &&
                     (!m_pend[sb_set_rd] || $urandom_range(0, 31) == 0);
      rs1      = REG_AW'($urandom_range(0, NREG - 1));
      rs2      = REG_AW'($urandom_range(0, NREG - 1));
      rs1_used = $urandom_range(0, 1);
      rs2_used = $urandom_range(0, 1);
      rst_n    = ($urandom_range(0, 499) != 0);
      cycle();
      a_hold = wb.a_valid && !e_ar;
      b_hold = wb.b_valid && !e_br;
    end
    rst_n = 1;
    idle_inputs();
    cycle();

`ifdef RFARB_PERF_EN
    // Drive the conflict counter into saturation.
    do_reset();
    wb.a_valid = 1; wb.a_rd = 1; wb.a_data = 5;
    wb.b_valid = 1; wb.b_rd = 2; wb.b_data = 6;
    for (int i = 0; i < 70000; i++) cycle();
    check_val("conflict_sat", 32'(conflict_cnt), 32'h0000_FFFF);
    idle_inputs();
    cycle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
